byte_lane_sequencer: RTL and testbench



---
 rtl/byte_lane_sequencer_pkg.sv | 33 +++
 rtl/byte_lane_sequencer_lane_timer.sv | 27 ++
 rtl/byte_lane_sequencer.sv | 171 +++++++++++++++++
 tb/tb_byte_lane_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/byte_lane_sequencer_pkg.sv
// rtl/byte_lane_sequencer_pkg.sv - shared types, constants and width helpers for byte_lane_sequencer
package byte_lane_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    NEXT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Byte returned for lanes that were never read or were aborted on timeout
  localparam logic [7:0] FILL_BYTE = 8'hff;

  function automatic int lanes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int lane_w_of(input int lanes);
    return (lanes <= 2) ? 1 : $clog2(lanes);
  endfunction

  // Enough bits to hold the timeout count itself; 1 bit minimum when disabled
  function automatic int to_w_of(input int timeout);
    return (timeout <= 1) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_lane_sequencer_lane_timer.sv
// rtl/byte_lane_sequencer_lane_timer.sv - loadable down-counter for wait states and sysrdy timeout
module byte_lane_sequencer_lane_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count
);

  // Load wins over decrement; nothing moves on ticks without en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      if (load) begin
        count <= load_val;
      end else if (dec) begin
        count <= count - W'(1);
      end
    end
  end

endmodule

// File: rtl/byte_lane_sequencer.sv
// rtl/byte_lane_sequencer.sv - splits a CPU word access into sequential byte cycles on the 8-bit bus
module byte_lane_sequencer
  import byte_lane_sequencer_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int WS_W    = 3,
  parameter int TIMEOUT = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clk_en,
  input  logic                             start,
  input  logic                             memen,
  input  logic                             we,
  input  logic                             sysrdy,
  input  logic [WS_W-1:0]                  wait_states,
  input  logic [0:DATA_W-1]                q,
  input  logic [0:7]                       d8,
  output logic                             ready,
  output logic                             memen8,
  output logic [lane_w_of(lanes_of(DATA_W))-1:0] a_lo,
  output logic [0:7]                       q8,
  output logic [0:DATA_W-1]                d,
  output logic                             timeout_err
);

  localparam int LANES  = lanes_of(DATA_W);
  localparam int LANE_W = lane_w_of(LANES);
  localparam int TO_W   = to_w_of(TIMEOUT);
  localparam int CNT_W  = max_of(WS_W, TO_W);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t              state, nxt;
  logic [LANE_W-1:0]   lane, lane_nxt;
  logic                t_load, t_dec;
  logic [CNT_W-1:0]    t_val, t_count;
  logic                cap_byte, fill_byte, err_set, err_clr;

  byte_lane_sequencer_lane_timer #(.W(CNT_W)) u_lane_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (clk_en),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .count    (t_count)
  );

  // Next-state, lane stepping and timer control; memen low mid-sequence aborts to IDLE
  always_comb begin
    nxt       = state;
    lane_nxt  = lane;
    t_load    = 1'b0;
    t_dec     = 1'b0;
    t_val     = '0;
    cap_byte  = 1'b0;
    fill_byte = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nxt      = SETUP;
          lane_nxt = LAST_LANE;
          err_clr  = 1'b1;
        end
      end
      SETUP: begin
        if (!memen) begin
          nxt      = IDLE;
          lane_nxt = LAST_LANE;
        end else if (wait_states == '0) begin
          nxt    = SAMPLE;
          t_load = 1'b1;
          t_val  = CNT_W'(TIMEOUT);
        end else begin
          nxt    = WAIT;
          t_load = 1'b1;
          t_val  = CNT_W'(wait_states);
        end
      end
      WAIT: begin
        if (!memen) begin
          nxt      = IDLE;
          lane_nxt = LAST_LANE;
        end else if (t_count == CNT_W'(1)) begin
          nxt    = SAMPLE;
          t_load = 1'b1;
          t_val  = CNT_W'(TIMEOUT);
        end else begin
          t_dec = 1'b1;
        end
      end
      SAMPLE: begin
        if (!memen) begin
          nxt      = IDLE;
          lane_nxt = LAST_LANE;
        end else if (sysrdy) begin
          nxt      = NEXT;
          cap_byte = !we;
        end else if (TIMEOUT != 0 && t_count == CNT_W'(1)) begin
          nxt       = NEXT;
          fill_byte = !we;
          err_set   = 1'b1;
        end else if (TIMEOUT != 0) begin
          t_dec = 1'b1;
        end
      end
      NEXT: begin
        if (!memen) begin
          nxt      = IDLE;
          lane_nxt = LAST_LANE;
        end else if (lane != '0) begin
          nxt      = SETUP;
          lane_nxt = lane - LANE_W'(1);
        end else begin
          nxt = DONE;
        end
      end
      DONE: begin
        if (!memen) begin
          nxt      = IDLE;
          lane_nxt = LAST_LANE;
        end
      end
      default: begin
        nxt      = IDLE;
        lane_nxt = LAST_LANE;
      end
    endcase
  end

  // State and lane register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      lane  <= LAST_LANE;
    end else if (clk_en) begin
      state <= nxt;
      lane  <= lane_nxt;
    end
  end

  // Byte data path: write byte chosen on SETUP entry, read bytes assembled big-endian, sticky abort flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q8          <= '0;
      d           <= '1;
      timeout_err <= 1'b0;
    end else if (clk_en) begin
      if (nxt == SETUP) begin
        q8 <= q[8*lane_nxt +: 8];
      end
      if (cap_byte) begin
        d[8*lane +: 8] <= d8;
      end else if (fill_byte) begin
        d[8*lane +: 8] <= FILL_BYTE;
      end
      if (err_clr) begin
        timeout_err <= 1'b0;
      end else if (err_set) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign ready  = (state == IDLE && !start) || (state == DONE);
  assign memen8 = (state == SETUP) || (state == WAIT) || (state == SAMPLE);
  assign a_lo   = lane;

endmodule

// File: tb/tb_byte_lane_sequencer.sv
// tb/tb_byte_lane_sequencer.sv - table-driven bench for byte_lane_sequencer (16-bit with timeout, 32-bit without)
module tb_byte_lane_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, clk_en, start16, start32, memen, we, sysrdy;
  logic [2:0]  wait_states;
  logic [0:15] q16;
  logic [0:31] q32;
  logic [0:7]  d8;

  logic        ready16, memen8_16, a_lo16, err16;
  logic [0:7]  q8_16;
  logic [0:15] d16;
  logic        ready32, memen8_32, err32;
  logic [1:0]  a_lo32;
  logic [0:7]  q8_32;
  logic [0:31] d32;

  always #5 clk = ~clk;

  byte_lane_sequencer #(.DATA_W(16), .WS_W(3), .TIMEOUT(8)) u16 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start16), .memen(memen),
    .we(we), .sysrdy(sysrdy), .wait_states(wait_states), .q(q16), .d8(d8),
    .ready(ready16), .memen8(memen8_16), .a_lo(a_lo16), .q8(q8_16), .d(d16),
    .timeout_err(err16)
  );

  byte_lane_sequencer #(.DATA_W(32), .WS_W(3), .TIMEOUT(0)) u32 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .start(start32), .memen(memen),
    .we(we), .sysrdy(sysrdy), .wait_states(wait_states), .q(q32), .d8(d8),
    .ready(ready32), .memen8(memen8_32), .a_lo(a_lo32), .q8(q8_32), .d(d32),
    .timeout_err(err32)
  );

  logic        sel;
  logic        cur_ready, cur_m8, cur_err;
  logic [1:0]  cur_alo;
  logic [7:0]  cur_q8;
  logic [31:0] cur_d;
  assign cur_ready = sel ? ready32 : ready16;
  assign cur_m8    = sel ? memen8_32 : memen8_16;
  assign cur_err   = sel ? err32 : err16;
  assign cur_alo   = sel ? a_lo32 : {1'b0, a_lo16};
  assign cur_q8    = sel ? q8_32 : q8_16;
  assign cur_d     = sel ? d32 : {16'h0000, d16};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             sel;
    logic             we;
    logic [2:0]       ws;
    logic [31:0]      q;
    logic [3:0][7:0]  b;
    int               stall;
    logic [31:0]      exp_d;
    int               exp_lat;
    int               exp_m8;
    logic             exp_err;
    logic [3:0][7:0]  eq8;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input int i, input vec_t v);
    int n, m8, nl, lanes;
    logic prev, done;
    logic [7:0] cap[4];
    lanes = v.sel ? 4 : 2;
    for (int k = 0; k < 4; k++) cap[k] = 8'h00;
    sel = v.sel; we = v.we; wait_states = v.ws;
    q16 = v.q[15:0]; q32 = v.q;
    sysrdy = (v.stall == 0);
    d8 = v.b[lanes-1];
    memen = 1'b1;
    if (v.sel) start32 = 1'b1; else start16 = 1'b1;
    tick();
    n = 0; m8 = 0; nl = lanes - 1; prev = 1'b0; done = 1'b0;
    while (!done) begin
      if (cur_m8) begin
        m8++;
        if (!prev) begin
          check($sformatf("r%0d_lane_order", i), {30'd0, cur_alo}, nl);
          nl--;
        end
        cap[cur_alo] = cur_q8;
      end
      prev = cur_m8;
      d8 = v.b[cur_alo];
      if (v.stall > 0 && n == v.stall + 1) sysrdy = 1'b1;
      if (cur_ready || n >= 100) done = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check($sformatf("r%0d_latency", i), n, v.exp_lat);
    check($sformatf("r%0d_memen8_ticks", i), m8, v.exp_m8);
    check($sformatf("r%0d_d", i), cur_d, v.exp_d);
    check($sformatf("r%0d_timeout_err", i), {31'd0, cur_err}, {31'd0, v.exp_err});
    for (int k = 0; k < lanes; k++)
      check($sformatf("r%0d_q8_lane%0d", i, k), {24'd0, cap[k]}, {24'd0, v.eq8[k]});
    memen = 1'b0; start16 = 1'b0; start32 = 1'b0; sysrdy = 1'b1;
    tick();
    check($sformatf("r%0d_idle_ready", i), {31'd0, cur_ready}, 32'd1);
    check($sformatf("r%0d_idle_a_lo", i), {30'd0, cur_alo}, lanes - 1);
  endtask

  initial begin
    int n;
    logic seen;
    //          sel we ws  q              b (lane3..0)   stall exp_d          lat m8 err eq8 (lane3..0)
    vecs[0] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_3412, 0, 32'h0000_1234,  6,  4, 1'b0, 32'h0000_0000};
    vecs[1] = '{1'b0, 1'b0, 3'd1, 32'h0000_beef, 32'h0000_cdab, 0, 32'h0000_abcd,  8,  6, 1'b0, 32'h0000_efbe};
    vecs[2] = '{1'b0, 1'b1, 3'd0, 32'h0000_5a6b, 32'h0000_7777, 0, 32'h0000_abcd,  6,  4, 1'b0, 32'h0000_6b5a};
    vecs[3] = '{1'b0, 1'b0, 3'd3, 32'h0000_0000, 32'h0000_00ff, 0, 32'h0000_ff00, 12, 10, 1'b0, 32'h0000_0000};
    vecs[4] = '{1'b1, 1'b1, 3'd2, 32'ha1b2_c3d4, 32'h0000_0000, 0, 32'hffff_ffff, 20, 16, 1'b0, 32'hd4c3_b2a1};
    vecs[5] = '{1'b1, 1'b0, 3'd0, 32'h0000_0000, 32'h1312_1110, 0, 32'h1011_1213, 12,  8, 1'b0, 32'h0000_0000};
    vecs[6] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_5678, 5, 32'h0000_7856, 11,  9, 1'b0, 32'h0000_0000};
    vecs[7] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_119a, 8, 32'h0000_9aff, 13, 11, 1'b1, 32'h0000_0000};
    vecs[8] = '{1'b0, 1'b0, 3'd0, 32'h0000_0000, 32'h0000_bcde, 7, 32'h0000_debc, 13, 11, 1'b0, 32'h0000_0000};

    reset_n = 1'b0; clk_en = 1'b1; start16 = 1'b0; start32 = 1'b0; memen = 1'b0;
    we = 1'b0; sysrdy = 1'b1; wait_states = 3'd0; q16 = '0; q32 = '0; d8 = '0; sel = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_ready16", {31'd0, ready16}, 32'd1);
    check("rst_memen8_16", {31'd0, memen8_16}, 32'd0);
    check("rst_a_lo16", {31'd0, a_lo16}, 32'd1);
    check("rst_q8_16", {24'd0, q8_16}, 32'd0);
    check("rst_d16", {16'd0, d16}, 32'h0000_ffff);
    check("rst_err16", {31'd0, err16}, 32'd0);
    check("rst_a_lo32", {30'd0, a_lo32}, 32'd3);
    check("rst_d32", d32, 32'hffff_ffff);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // memen dropped in lane-1 WAIT: back to IDLE at once, no lane-0 cycle, d untouched
    sel = 1'b0; we = 1'b0; wait_states = 3'd3; sysrdy = 1'b1; d8 = 8'h55;
    start16 = 1'b1; memen = 1'b1;
    tick(); tick();
    check("abort_in_wait_m8", {31'd0, memen8_16}, 32'd1);
    memen = 1'b0; start16 = 1'b0;
    tick();
    check("abort_memen8", {31'd0, memen8_16}, 32'd0);
    check("abort_ready", {31'd0, ready16}, 32'd1);
    check("abort_a_lo", {31'd0, a_lo16}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (memen8_16) seen = 1'b1;
    end
    check("abort_no_lane0", {31'd0, seen}, 32'd0);
    check("abort_d", {16'd0, d16}, 32'h0000_debc);

    // Asynchronous reset pulse between edges mid-access
    q16 = 16'h1357; wait_states = 3'd3; start16 = 1'b1; memen = 1'b1;
    tick(); tick();
    check("prerst_q8", {24'd0, q8_16}, 32'h0000_0057);
    #2;
    start16 = 1'b0; memen = 1'b0; reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    check("arst_memen8", {31'd0, memen8_16}, 32'd0);
    check("arst_a_lo", {31'd0, a_lo16}, 32'd1);
    check("arst_q8", {24'd0, q8_16}, 32'd0);
    check("arst_d", {16'd0, d16}, 32'h0000_ffff);
    check("arst_err", {31'd0, err16}, 32'd0);
    check("arst_ready", {31'd0, ready16}, 32'd1);
    check("arst_d32", d32, 32'hffff_ffff);

    // clk_en low freezes everything, both in IDLE and mid-sequence
    tick();
    wait_states = 3'd0; d8 = 8'h42; clk_en = 1'b0; start16 = 1'b1; memen = 1'b1;
    tick(); tick(); tick();
    check("freeze_idle_m8", {31'd0, memen8_16}, 32'd0);
    check("freeze_idle_ready", {31'd0, ready16}, 32'd0);
    clk_en = 1'b1;
    tick();
    check("freeze_setup_m8", {31'd0, memen8_16}, 32'd1);
    clk_en = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("freeze_hold_m8", {31'd0, memen8_16}, 32'd1);
    check("freeze_hold_a_lo", {31'd0, a_lo16}, 32'd1);
    clk_en = 1'b1;
    n = 0;
    while (!ready16 && n < 100) begin
      tick();
      n++;
    end
    check("freeze_latency", n, 32'd6);
    check("freeze_d", {16'd0, d16}, 32'h0000_4242);
    memen = 1'b0; start16 = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
